i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- I2C target (slave) endpoint that answers transactions started by the team's I2C controller datapath on the same two-wire bus.
- Oversamples SCL/SDA on a local system clock; detects START/STOP; matches a 7-bit address; ACKs; shifts bytes in (controller write) or out (controller read).
- Presents a byte-wide rx/tx interface to a register file or FIFO on the user side.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit bus address this target responds to.

Ports:
- i2c_clk_in  input  1  system clock; frequency must be at least 10x SCL.
- resetN  input  1  asynchronous, active-low reset.
- scl_in  input  1  raw bus SCL (asynchronous to i2c_clk_in).
- sda_in  input  1  raw bus SDA (asynchronous to i2c_clk_in).
- sda_oe  output  1  1 = pull SDA low (open drain); 0 = release.
- rx_data  output  8  last byte received from controller.
- rx_valid  output  1  one-cycle pulse; rx_data is new.
- rx_ready  input  1  user can accept a byte; sampled to choose ACK/NACK.
- tx_data  input  8  byte to send on a controller read.
- tx_req  output  1  one-cycle pulse requesting the next tx_data.
- rw  output  1  R/W bit of the current transaction (1 = read).
- busy  output  1  high from address match until STOP or NACK termination.
- nack_rx  output  1  one-cycle pulse when the controller NACKs a read byte.

Behaviour:
- Reset (async, resetN=0):
  - Outputs: sda_oe=0, rx_data=0, rx_valid=0, tx_req=0, rw=0, busy=0, nack_rx=0.
  - Internal: state=IDLE, bit counter=7, shift register=0.
  - sda_oe releases immediately, even mid-byte.
- Synchronizer: 2-flop sync on scl_in and sda_in, plus a third stage for edge detect. Effective input latency is 3 clk.
  - SCL rise/fall = sync stage2 != stage3.
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
- Bit timing:
  - Data sampled on the synchronized SCL rising edge.
  - sda_oe changes only on the synchronized SCL falling edge.
  - All bytes are MSB first; the counter counts 7 down to 0.
- States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
  - Any state, START seen: -> ADDR, counter=7, sda_oe=0. This covers repeated START.
  - Any state, STOP seen: -> IDLE, busy=0, sda_oe=0.
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + rw).
    - Match (shift[7:1]==TARGET_ADDR): latch rw, busy=1, -> ADDR_ACK.
    - Mismatch: -> WAIT_STOP. Never drive SDA.
  - ADDR_ACK: on the next SCL fall, sda_oe=1; on the following SCL fall, release.
    - rw=0: -> WR_DATA, releasing SDA.
    - rw=1: -> RD_DATA, driving tx_data[7].
    - If rw=1, tx_req pulses on the SCL rise of the ACK clock. tx_data is sampled at the following SCL fall, so the user has at least one SCL-high period to present it.
  - WR_DATA: shift 8 bits.
    - On the 8th rise: rx_data <= shifted byte, rx_valid pulse (same cycle), sample rx_ready, -> WR_ACK.
    - A byte is delivered even if it will be NACKed.
  - WR_ACK: sda_oe=rx_ready (as sampled) during the 9th clock.
    - After release: if ACKed -> WR_DATA, else -> WAIT_STOP.
  - RD_DATA: drive bit[counter] (inverted onto sda_oe: bit 0 -> oe=1) on each SCL fall.
    - After the 8th bit's SCL fall, release SDA and -> RD_ACK.
  - RD_ACK: sample SDA on the 9th rise.
    - 0 (ACK): tx_req pulse, -> RD_DATA; the next byte loads on the next SCL fall.
    - 1 (NACK): nack_rx pulse, busy=0, -> WAIT_STOP.
  - WAIT_STOP: ignore bus until START or STOP.
- Simultaneous events: START/STOP detection takes priority over SCL-edge processing in the same clk.
- Address 7'h00 (general call) is treated as a mismatch unless TARGET_ADDR=0.
- rx_valid, tx_req and nack_rx are exactly one i2c_clk_in cycle wide.

Test Plan:
- Write to match, rx_ready=1:
  - Stimulus: TARGET_ADDR=7'h50; controller START, 0xA0, 0x3C, 0x81, STOP.
  - Required: ACK on all 3 bytes; rx_valid pulses twice with rx_data=0x3C then 0x81; busy 1->0 at STOP.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x55, STOP.
  - Required: sda_oe stays 0 throughout; no rx_valid; busy stays 0.
- Read, ACK then NACK:
  - Stimulus: START, 0xA1; user answers tx_req with 0xC5 then 0x0F; controller ACKs byte 1, NACKs byte 2.
  - Required: bus carries 0xC5, 0x0F; tx_req pulses exactly twice; nack_rx pulses once; busy=0.
- Back-pressure:
  - Stimulus: write 0xA0, 0x11 with rx_ready=0.
  - Required: rx_valid pulses with 0x11; 9th bit NACK (sda_oe=0); block ignores further bytes until STOP.
- Repeated START:
  - Stimulus: START, 0xA0, 0x07, repeated START, 0xA1, read 1 byte (tx_data=0x99), NACK, STOP.
  - Required: rx_data=0x07; rw flips 0->1; bus carries 0x99.
- Reset mid-read:
  - Stimulus: resetN=0 while driving a 0 bit.
  - Required: sda_oe=0 same cycle; all outputs at reset values; the next START with 0xA0 is ACKed normally.

Source files
------------

// File: rtl/i2c_target_if.sv
// Bus pins and user-side byte port of the I2C target, bundled for port connection.
interface i2c_target_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rw;
  logic       busy;
  logic       nack_rx;

  modport slave (
    input  scl_in, sda_in, rx_ready, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, rw, busy, nack_rx
  );

  modport master (
    output scl_in, sda_in, rx_ready, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, rw, busy, nack_rx
  );
endinterface

// File: rtl/i2c_target.sv
// Oversampled I2C target: START/STOP detect, 7-bit address match, byte receive with
// user back-pressure ACK/NACK, and byte transmit on controller reads.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in 7-bit address + R/W
// ADDR_ACK  | driving the address ACK (9th clock)
// WR_DATA   | shifting in a write byte
// WR_ACK    | driving ACK/NACK for the write byte
// RD_DATA   | driving a read byte, MSB first
// RD_ACK    | sampling the controller's ACK/NACK
// WAIT_STOP | ignoring the bus until START or STOP
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic        i2c_clk_in,
  input  logic        resetN,
  i2c_target_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] scl_sync_q, scl_sync_d;
  logic [2:0] sda_sync_q, sda_sync_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ph_q, ph_d;
  logic       ld_q, ld_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       rw_q, rw_d;
  logic       busy_q, busy_d;
  logic       nack_rx_q, nack_rx_d;

  logic       scl_rise, scl_fall, start_det, stop_det, sda_bit, last_bit, addr_match;
  logic [7:0] shift_in;
  logic [2:0] cnt_m1;

  // Stage [1] is the synchronized value, stage [2] the previous one for edge detect.
  assign scl_sync_d = {scl_sync_q[1:0], bus.scl_in};
  assign sda_sync_d = {sda_sync_q[1:0], bus.sda_in};

  assign scl_rise   = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det  = scl_sync_q[1] & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_det   = scl_sync_q[1] & sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_bit    = sda_sync_q[1];
  assign shift_in   = {shift_q[6:0], sda_bit};
  assign last_bit   = (cnt_q == 3'd0);
  assign cnt_m1     = cnt_q - 3'd1;
  assign addr_match = (shift_in[7:1] == TARGET_ADDR);

  always_ff @(posedge i2c_clk_in or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      cnt_q      <= 3'd7;
      shift_q    <= 8'h00;
      ph_q       <= 1'b0;
      ld_q       <= 1'b0;
      ack_q      <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      nack_rx_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      ph_q       <= ph_d;
      ld_q       <= ld_d;
      ack_q      <= ack_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      nack_rx_q  <= nack_rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise && last_bit) begin
            if (addr_match) state_d = ADDR_ACK;
            else            state_d = WAIT_STOP;
          end
        end
        ADDR_ACK: begin
          if (scl_fall && ph_q) begin
            if (rw_q) state_d = RD_DATA;
            else      state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          if (scl_rise && last_bit) state_d = WR_ACK;
        end
        WR_ACK: begin
          if (scl_fall && ph_q) begin
            if (ack_q) state_d = WR_DATA;
            else       state_d = WAIT_STOP;
          end
        end
        RD_DATA: begin
          if (scl_fall && !ld_q && last_bit) state_d = RD_ACK;
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_bit) state_d = WAIT_STOP;
            else         state_d = RD_DATA;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    ph_d       = ph_q;
    ld_d       = ld_q;
    ack_d      = ack_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    nack_rx_d  = 1'b0;
    if (start_det) begin
      cnt_d    = 3'd7;
      sda_oe_d = 1'b0;
      ph_d     = 1'b0;
      ld_d     = 1'b0;
    end else if (stop_det) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      ph_d     = 1'b0;
      ld_d     = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (!last_bit) begin
              cnt_d = cnt_m1;
            end else if (addr_match) begin
              rw_d   = shift_in[0];
              busy_d = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && ph_q && rw_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!ph_q) begin
              sda_oe_d = 1'b1;
              ph_d     = 1'b1;
            end else begin
              ph_d  = 1'b0;
              cnt_d = 3'd7;
              if (rw_q) begin
                shift_d  = bus.tx_data;
                sda_oe_d = ~bus.tx_data[7];
              end else begin
                sda_oe_d = 1'b0;
              end
            end
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (last_bit) begin
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              ack_d      = bus.rx_ready;
            end else begin
              cnt_d = cnt_m1;
            end
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            if (!ph_q) begin
              sda_oe_d = ack_q;
              ph_d     = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ph_d     = 1'b0;
              cnt_d    = 3'd7;
              if (!ack_q) busy_d = 1'b0;
            end
          end
        end
        RD_DATA: begin
          // Open drain: a 0 bit is driven by pulling SDA low.
          if (scl_fall) begin
            if (ld_q) begin
              shift_d  = bus.tx_data;
              sda_oe_d = ~bus.tx_data[7];
              cnt_d    = 3'd7;
              ld_d     = 1'b0;
            end else if (last_bit) begin
              sda_oe_d = 1'b0;
            end else begin
              sda_oe_d = ~shift_q[cnt_m1];
              cnt_d    = cnt_m1;
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (!sda_bit) begin
              tx_req_d = 1'b1;
              ld_d     = 1'b1;
            end else begin
              nack_rx_d = 1'b1;
              busy_d    = 1'b0;
            end
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.tx_req   = tx_req_q;
  assign bus.rw       = rw_q;
  assign bus.busy     = busy_q;
  assign bus.nack_rx  = nack_rx_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-level bus controller, a user-side byte responder
// and a per-cycle SDA-drive checker fed by the expected bus behaviour of each bit.
module tb_i2c_target;
  logic clk = 1'b0;
  logic rst_n;
  logic scl_m, sda_m;
  int   tests = 0;
  int   fails = 0;

  logic chk_oe = 1'b0;
  logic exp_oe = 1'b0;
  logic quiet  = 1'b0;
  int   n_rx   = 0;
  int   n_tx   = 0;
  int   n_nack = 0;
  logic [7:0] rx_got[$];
  logic [7:0] tx_rom [4] = '{8'hC5, 8'h0F, 8'h99, 8'h3C};
  logic prev_rxv = 1'b0, prev_txr = 1'b0, prev_nk = 1'b0;

  i2c_target_if bus ();

  i2c_target #(.TARGET_ADDR(7'h50)) dut (
    .i2c_clk_in (clk),
    .resetN     (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Open-drain wired-AND of controller and target on SDA.
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_data = 8'h00;
    end else begin
      if (chk_oe) check("sda_oe_bit", {31'b0, bus.sda_oe}, {31'b0, exp_oe});
      if (quiet) begin
        check("quiet_sda_oe", {31'b0, bus.sda_oe}, 32'd0);
        check("quiet_busy", {31'b0, bus.busy}, 32'd0);
      end
      if (prev_rxv) check("rx_valid_width", {31'b0, bus.rx_valid}, 32'd0);
      if (prev_txr) check("tx_req_width", {31'b0, bus.tx_req}, 32'd0);
      if (prev_nk)  check("nack_rx_width", {31'b0, bus.nack_rx}, 32'd0);
      if (bus.rx_valid) begin
        rx_got.push_back(bus.rx_data);
        n_rx++;
      end
      if (bus.tx_req) begin
        bus.tx_data = (n_tx < 4) ? tx_rom[n_tx] : 8'hFF;
        n_tx++;
      end
      if (bus.nack_rx) n_nack++;
    end
    prev_rxv = bus.rx_valid;
    prev_txr = bus.tx_req;
    prev_nk  = bus.nack_rx;
  end

  // One SCL period (20 clk); eo is what the target must be doing to SDA while SCL is high.
  task automatic clock_bit(input logic b, input logic eo, output logic seen);
    sda_m  = b;
    exp_oe = eo;
    #50; scl_m = 1'b1;
    #10; chk_oe = 1'b1;
    #40; seen = bus.sda_in;
    #50; chk_oe = 1'b0; scl_m = 1'b0;
    #50;
  endtask

  task automatic bus_start();
    sda_m = 1'b1; #50; scl_m = 1'b1; #50; sda_m = 1'b0; #50; scl_m = 1'b0; #50;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #50; scl_m = 1'b1; #50; sda_m = 1'b1; #100;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], 1'b0, s);
    clock_bit(1'b1, ack, s);
  endtask

  task automatic read_byte(input logic [7:0] b, input logic m_ack, output logic [7:0] got);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, ~b[i], s);
      got[i] = s;
    end
    clock_bit(~m_ack, 1'b0, s);
  endtask

  initial begin
    logic [7:0] got;
    int b_rx, b_q, b_tx, b_nk;
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    bus.rx_ready = 1'b1;
    #22;
    check("rst_sda_oe",   {31'b0, bus.sda_oe},   32'd0);
    check("rst_rx_data",  {24'b0, bus.rx_data},  32'd0);
    check("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("rst_tx_req",   {31'b0, bus.tx_req},   32'd0);
    check("rst_rw",       {31'b0, bus.rw},       32'd0);
    check("rst_busy",     {31'b0, bus.busy},     32'd0);
    check("rst_nack_rx",  {31'b0, bus.nack_rx},  32'd0);
    rst_n = 1'b1;
    #100;

    // Write to matching address, all ACKed
    b_rx = n_rx; b_q = rx_got.size();
    bus_start();
    write_byte(8'hA0, 1'b1);
    check("w_busy", {31'b0, bus.busy}, 32'd1);
    check("w_rw", {31'b0, bus.rw}, 32'd0);
    write_byte(8'h3C, 1'b1);
    write_byte(8'h81, 1'b1);
    check("w_rx_data", {24'b0, bus.rx_data}, 32'h81);
    bus_stop();
    check("w_busy_stop", {31'b0, bus.busy}, 32'd0);
    check("w_rx_cnt", n_rx - b_rx, 32'd2);
    check("w_rx0", {24'b0, rx_got[b_q]}, 32'h3C);
    check("w_rx1", {24'b0, rx_got[b_q + 1]}, 32'h81);

    // Address mismatch
    b_rx = n_rx;
    quiet = 1'b1;
    bus_start();
    write_byte(8'hA2, 1'b0);
    write_byte(8'h55, 1'b0);
    bus_stop();
    quiet = 1'b0;
    check("mm_rx_cnt", n_rx - b_rx, 32'd0);

    // Read: ACK first byte, NACK second
    b_tx = n_tx; b_nk = n_nack;
    bus_start();
    write_byte(8'hA1, 1'b1);
    check("r_rw", {31'b0, bus.rw}, 32'd1);
    check("r_busy", {31'b0, bus.busy}, 32'd1);
    read_byte(8'hC5, 1'b1, got);
    check("r_byte0", {24'b0, got}, 32'hC5);
    read_byte(8'h0F, 1'b0, got);
    check("r_byte1", {24'b0, got}, 32'h0F);
    check("r_busy_nack", {31'b0, bus.busy}, 32'd0);
    check("r_tx_req_cnt", n_tx - b_tx, 32'd2);
    check("r_nack_cnt", n_nack - b_nk, 32'd1);
    bus_stop();

    // Back-pressure: byte delivered then NACKed, later bytes ignored
    b_rx = n_rx; b_q = rx_got.size();
    bus.rx_ready = 1'b0;
    bus_start();
    write_byte(8'hA0, 1'b1);
    write_byte(8'h11, 1'b0);
    check("bp_rx_data", {24'b0, bus.rx_data}, 32'h11);
    write_byte(8'h22, 1'b0);
    bus_stop();
    bus.rx_ready = 1'b1;
    check("bp_rx_cnt", n_rx - b_rx, 32'd1);
    check("bp_rx0", {24'b0, rx_got[b_q]}, 32'h11);
    check("bp_busy", {31'b0, bus.busy}, 32'd0);

    // Repeated START: write then read
    b_rx = n_rx; b_tx = n_tx;
    bus_start();
    write_byte(8'hA0, 1'b1);
    write_byte(8'h07, 1'b1);
    check("rs_rw_wr", {31'b0, bus.rw}, 32'd0);
    bus_start();
    write_byte(8'hA1, 1'b1);
    check("rs_rw_rd", {31'b0, bus.rw}, 32'd1);
    read_byte(8'h99, 1'b0, got);
    check("rs_byte", {24'b0, got}, 32'h99);
    bus_stop();
    check("rs_rx_data", {24'b0, bus.rx_data}, 32'h07);
    check("rs_rx_cnt", n_rx - b_rx, 32'd1);
    check("rs_tx_cnt", n_tx - b_tx, 32'd1);

    // Reset while the target is pulling SDA low for a 0 bit (0x3C, MSB = 0)
    bus_start();
    write_byte(8'hA1, 1'b1);
    sda_m = 1'b1;
    #50; scl_m = 1'b1;
    #50;
    check("mr_pre_oe", {31'b0, bus.sda_oe}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr_sda_oe",   {31'b0, bus.sda_oe},   32'd0);
    check("mr_busy",     {31'b0, bus.busy},     32'd0);
    check("mr_rw",       {31'b0, bus.rw},       32'd0);
    check("mr_rx_data",  {24'b0, bus.rx_data},  32'd0);
    check("mr_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    check("mr_tx_req",   {31'b0, bus.tx_req},   32'd0);
    check("mr_nack_rx",  {31'b0, bus.nack_rx},  32'd0);
    #49;
    rst_n = 1'b1;
    #50;
    bus_start();
    write_byte(8'hA0, 1'b1);
    check("mr_busy_after", {31'b0, bus.busy}, 32'd1);
    bus_stop();
    check("mr_busy_stop", {31'b0, bus.busy}, 32'd0);

    #100;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
